// File: rtl/bp_be_fe_queue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_fe_queue_buffer
//  Purpose  : Backend-side receiver for the frontend fetch queue. Buffers
//             fetch messages in a circular array, hands them to issue
//             speculatively, and keeps every entry until it is committed so
//             that a rollback can replay the uncommitted messages.
//  Revision : 1.0  initial release
// ============================================================================
module bp_be_fe_queue_buffer #(
    parameter int fe_queue_width_p = 0,
    parameter int els_p            = 8,
    localparam int ptr_width_lp    = $clog2(els_p) + 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [fe_queue_width_p-1:0] fe_queue_i,
    input  logic                        fe_queue_v_i,
    output logic                        fe_queue_ready_and_o,

    output logic [fe_queue_width_p-1:0] fe_queue_o,
    output logic                        fe_queue_v_o,
    input  logic                        fe_queue_yumi_i,

    input  logic                        commit_v_i,
    input  logic                        roll_v_i,
    input  logic                        clr_v_i,

    output logic                        empty_o,
    output logic                        full_o,
    output logic [ptr_width_lp-1:0]     count_o
);

    // Low pointer bits index storage; the extra MSB is the wrap bit that
    // distinguishes full from empty when the low bits match.
    localparam int                    c_IDX_W   = ptr_width_lp - 1;
    localparam logic [ptr_width_lp-1:0] c_PTR_ONE = ptr_width_lp'(1);
    localparam logic [ptr_width_lp-1:0] c_PTR_ZERO = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [fe_queue_width_p-1:0] r_mem [els_p];
    logic [ptr_width_lp-1:0]     r_wptr;   // next slot to write
    logic [ptr_width_lp-1:0]     r_rptr;   // next slot to hand to issue
    logic [ptr_width_lp-1:0]     r_cptr;   // oldest uncommitted slot

    // ------------------------------------------------------------------------
    // Combinational status and handshake terms
    // ------------------------------------------------------------------------
    logic                        w_full;
    logic                        w_empty;
    logic                        w_ready;
    logic                        w_v_out;
    logic                        w_enq;
    logic                        w_yumi;
    logic                        w_commit;
    logic [ptr_width_lp-1:0]     w_cptr_next;
    logic [ptr_width_lp-1:0]     w_rptr_adv;
    logic [ptr_width_lp-1:0]     w_rptr_next;
    logic [c_IDX_W-1:0]          w_widx;
    logic [c_IDX_W-1:0]          w_ridx;

    assign w_widx  = r_wptr[c_IDX_W-1:0];
    assign w_ridx  = r_rptr[c_IDX_W-1:0];

    assign w_full  = (r_wptr[c_IDX_W] != r_cptr[c_IDX_W]) &&
                     (r_wptr[c_IDX_W-1:0] == r_cptr[c_IDX_W-1:0]);
    assign w_empty = (r_wptr == r_cptr);

    // Space is judged from the registered commit pointer only, so a commit
    // frees its slot for enqueue one cycle later.
    assign w_ready = ~w_full & ~clr_v_i;
    assign w_v_out = (r_rptr != r_wptr) & ~clr_v_i;

    assign w_enq    = fe_queue_v_i & w_ready;
    // A yumi without a valid message is ignored; this also masks the yumi
    // during a clear, where v_o is forced low.
    assign w_yumi   = fe_queue_yumi_i & w_v_out;
    assign w_commit = commit_v_i & ~clr_v_i;

    assign w_cptr_next = w_commit ? (r_cptr + c_PTR_ONE) : r_cptr;
    assign w_rptr_adv  = w_yumi   ? (r_rptr + c_PTR_ONE) : r_rptr;
    // Roll rewinds to the commit pointer including a same-cycle commit and
    // discards a same-cycle yumi.
    assign w_rptr_next = roll_v_i ? w_cptr_next : w_rptr_adv;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fe_queue_ready_and_o = w_ready;
    assign fe_queue_v_o         = w_v_out;
    assign fe_queue_o           = w_v_out ? r_mem[w_ridx] : '0;
    assign empty_o              = w_empty;
    assign full_o               = w_full;
    assign count_o              = r_wptr - r_cptr;

    // Message storage: written on accepted enqueue, never reset.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[w_widx] <= fe_queue_i;
        end
    end

    // Pointer update: clear beats everything, otherwise each pointer moves
    // independently (roll beats yumi for the read pointer).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= c_PTR_ZERO;
            r_rptr <= c_PTR_ZERO;
            r_cptr <= c_PTR_ZERO;
        end else if (clr_v_i) begin
            r_wptr <= c_PTR_ZERO;
            r_rptr <= c_PTR_ZERO;
            r_cptr <= c_PTR_ZERO;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            r_rptr <= w_rptr_next;
            r_cptr <= w_cptr_next;
        end
    end

`ifndef SYNTHESIS
    // A commit may only retire an entry that has been read, counting a read
    // that happens in the same cycle.
    always @(posedge clk_i) begin
        if (!reset_i && w_commit) begin
            assert (r_cptr != w_rptr_adv);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_be_fe_queue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_be_fe_queue_buffer
//  Purpose  : Self-checking bench for bp_be_fe_queue_buffer: directed vector
//             table, streaming order check, random traffic against a queue
//             model, and asynchronous reset mid-stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_be_fe_queue_buffer;

    localparam int W = 16;
    localparam int N = 8;
    localparam int PW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  fe_in;
    logic          fe_v_in;
    logic          fe_ready;
    logic [W-1:0]  fe_out;
    logic          fe_v_out;
    logic          yumi;
    logic          commit;
    logic          roll;
    logic          clr;
    logic          empty;
    logic          full;
    logic [PW-1:0] count;

    always #5 clk = ~clk;

    bp_be_fe_queue_buffer #(.fe_queue_width_p(W), .els_p(N)) dut (
        .clk_i                (clk),
        .reset_i              (rst),
        .fe_queue_i           (fe_in),
        .fe_queue_v_i         (fe_v_in),
        .fe_queue_ready_and_o (fe_ready),
        .fe_queue_o           (fe_out),
        .fe_queue_v_o         (fe_v_out),
        .fe_queue_yumi_i      (yumi),
        .commit_v_i           (commit),
        .roll_v_i             (roll),
        .clr_v_i              (clr),
        .empty_o              (empty),
        .full_o               (full),
        .count_o              (count)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         y, c, r, x;
        logic         e_rdy, e_v;
        logic [W-1:0] e_d;
        int           e_cnt;
        logic         e_emp, e_full;
    } vec_t;

    vec_t tbl[$];

    // Reference model: held entries oldest-first, plus how many of them
    // have been handed to issue but not committed.
    logic [W-1:0] mq[$];
    int           mrd;

    int n_vec = 0;
    int n_err = 0;

    function automatic void add(input logic v, input int d, input logic y, c, r, x,
                                input logic e_rdy, e_v, input int e_d, input int e_cnt,
                                input logic e_emp, e_full);
        vec_t t;
        t.v = v; t.d = W'(d); t.y = y; t.c = c; t.r = r; t.x = x;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_d = W'(e_d); t.e_cnt = e_cnt;
        t.e_emp = e_emp; t.e_full = e_full;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic y, c, r, x);
        fe_v_in = v; fe_in = d; yumi = y; commit = c; roll = r; clr = x;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_v();
        return (mrd < mq.size()) && !clr;
    endfunction

    function automatic logic m_rdy();
        return (mq.size() < N) && !clr;
    endfunction

    // Compare every output against the model for the current inputs.
    task automatic model_check();
        chk("ready", int'(fe_ready), int'(m_rdy()));
        chk("v_o",   int'(fe_v_out), int'(m_v()));
        chk("data",  int'(fe_out),   m_v() ? int'(mq[mrd]) : 0);
        chk("count", int'(count),    mq.size());
        chk("empty", int'(empty),    int'(mq.size() == 0));
        chk("full",  int'(full),     int'(mq.size() == N));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_step();
        logic acc;
        logic yy;
        acc = fe_v_in && m_rdy();
        yy  = yumi && m_v();
        if (clr) begin
            mq.delete();
            mrd = 0;
        end else begin
            if (commit) begin
                void'(mq.pop_front());
                mrd--;
            end
            mrd = roll ? 0 : mrd + int'(yy);
            if (acc) mq.push_back(fe_in);
        end
    endfunction

    initial begin
        int seq;
        int exp_next;
        int sent;
        logic v, y, c;

        rst = 1'b1;
        drive(0, '0, 0, 0, 0, 0);
        mq.delete();
        mrd = 0;

        // ---------------- directed table ----------------
        // Fill 8 then offer a 9th that must be refused.
        for (int i = 0; i <= 8; i++)
            add(1, i + 1, 0, 0, 0, 0, i < 8, i > 0, (i > 0) ? 1 : 0, i, i == 0, i == 8);
        // Drain with yumi+commit each cycle.
        for (int j = 0; j < 8; j++)
            add(0, 0, 1, 1, 0, 0, j != 0, 1, j + 1, 8 - j, 0, j == 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        // Rollback replay.
        add(1, 'hA, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0);
        add(1, 'hB, 0, 0, 0, 0, 1, 1, 'hA, 1, 0, 0);
        add(1, 'hC, 0, 0, 0, 0, 1, 1, 'hA, 2, 0, 0);
        add(0, 0,   1, 0, 0, 0, 1, 1, 'hA, 3, 0, 0);
        add(0, 0,   1, 0, 0, 0, 1, 1, 'hB, 3, 0, 0);
        add(0, 0,   1, 0, 0, 0, 1, 1, 'hC, 3, 0, 0);
        add(0, 0,   0, 1, 0, 0, 1, 0, 0,   3, 0, 0);
        add(0, 0,   0, 0, 1, 0, 1, 0, 0,   2, 0, 0);
        add(0, 0,   1, 0, 0, 0, 1, 1, 'hB, 2, 0, 0);
        add(0, 0,   1, 0, 0, 0, 1, 1, 'hC, 2, 0, 0);
        add(0, 0,   0, 1, 0, 0, 1, 0, 0,   2, 0, 0);
        add(0, 0,   0, 1, 0, 0, 1, 0, 0,   1, 0, 0);
        add(0, 0,   0, 0, 0, 0, 1, 0, 0,   0, 1, 0);
        // Clear priority with 5 entries held.
        for (int i = 0; i < 5; i++)
            add(1, 'h10 + i, 0, 0, 0, 0, 1, i > 0, (i > 0) ? 'h10 : 0, i, i == 0, 0);
        add(1, 'hF, 1, 1, 1, 1, 0, 0, 0, 5, 0, 0);
        add(0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        model_check();
        tick();

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].d, tbl[k].y, tbl[k].c, tbl[k].r, tbl[k].x);
            #3;
            chk("tbl_ready", int'(fe_ready), int'(tbl[k].e_rdy));
            chk("tbl_v_o",   int'(fe_v_out), int'(tbl[k].e_v));
            chk("tbl_data",  int'(fe_out),   int'(tbl[k].e_d));
            chk("tbl_count", int'(count),    tbl[k].e_cnt);
            chk("tbl_empty", int'(empty),    int'(tbl[k].e_emp));
            chk("tbl_full",  int'(full),     int'(tbl[k].e_full));
            tick();
        end
        mq.delete();
        mrd = 0;

        // ---------------- streaming 0..19 across pointer wrap ----------------
        exp_next = 0;
        sent     = 0;
        for (int cyc = 0; cyc < 300 && exp_next < 20; cyc++) begin
            clr = 1'b0; roll = 1'b0;
            v = (sent < 20) && ($urandom_range(0, 3) != 0);
            y = m_v() && ($urandom_range(0, 2) == 0);
            c = ((mrd + int'(y)) > 0) && ($urandom_range(0, 1) == 0);
            drive(v, W'(sent), y, c, 0, 0);
            #3;
            model_check();
            if (y) begin
                chk("stream_order", int'(fe_out), exp_next);
                exp_next++;
            end
            if (v && m_rdy()) sent++;
            tick();
            model_step();
        end
        chk("stream_done", exp_next, 20);

        // ---------------- random traffic against the model ----------------
        seq = 'h100;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            clr = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 3) != 0);
            y   = m_v() && ($urandom_range(0, 1) == 0);
            c   = ((mrd + int'(y)) > 0) && ($urandom_range(0, 1) == 0);
            drive(v, W'(seq), y, c, ($urandom_range(0, 15) == 0), clr);
            #3;
            model_check();
            if (v && m_rdy()) seq++;
            tick();
            model_step();
        end

        // ---------------- asynchronous reset mid-stream ----------------
        drive(0, '0, 0, 0, 0, 1);
        tick();
        model_step();
        for (int i = 0; i < 4; i++) begin
            drive(1, W'('h50 + i), 0, 0, 0, 0);
            tick();
            model_step();
        end
        drive(0, '0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_count", int'(count), 4);
        #1 rst = 1'b1;
        #1;
        chk("arst_v_o",   int'(fe_v_out), 0);
        chk("arst_empty", int'(empty),    1);
        chk("arst_count", int'(count),    0);
        chk("arst_ready", int'(fe_ready), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        mq.delete();
        mrd = 0;
        @(posedge clk);
        #4;
        model_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
